ps2_host_tx: RTL
================

Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends one command byte, such as 0xED (set LEDs) or 0xFF (reset), from the FPGA to the keyboard over the shared open-drain keyClock/keyData lines. It shares the lines with the existing PS/2 scan-code receiver; txBusy lets higher logic gate that receiver during a transmit. Framing is 1 start bit, 8 data bits LSB first, odd parity, 1 stop bit, then the device's ack bit.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles keyClock is held low before the request (100 us at 50 MHz).
SETUP_CYCLES, 100, clk cycles keyData is held low together with keyClock before keyClock is released.
TIMEOUT_CYCLES, 750000, maximum clk cycles from keyClock release to return to idle (15 ms at 50 MHz).

Ports:
clk  input  1  system clock; all state is posedge clk.
reset  input  1  asynchronous, active-low reset.
txData  input  8  command byte; sampled on an accepted txStart.
txStart  input  1  one-cycle request; accepted only when txBusy=0.
txBusy  output  1  high from the cycle after acceptance until return to IDLE.
txDone  output  1  one-cycle pulse when the frame completes normally.
txAck  output  1  ack result, valid while txDone=1 and held until the next acceptance: 1 = device drove ack low.
txError  output  1  one-cycle pulse on timeout.
keyClock  inout  1  open-drain PS/2 clock; driven 0 or released to 'z'.
keyData  inout  1  open-drain PS/2 data; driven 0 or released to 'z'.

Behaviour:
- Reset (async, reset=0): state IDLE; both lines released immediately; txBusy=0, txDone=0, txError=0, txAck=0; counters and sync flops cleared.
- Sync: keyClock passes through a 3-flop chain. negEdge = ~r1 & r2. keyData passes through a 2-flop sync (dSync). Internal decisions use only synced values.
- Parity: latched as ~^txData at acceptance.
- IDLE: both lines released. On txStart: latch the byte and parity, clear counters, go to INHIBIT.
- INHIBIT: drive keyClock=0 and release keyData for INHIBIT_CYCLES cycles, then go to REQ.
- REQ: drive keyClock=0 and keyData=0 for SETUP_CYCLES cycles. Then release keyClock, clear the timeout counter and bitIdx, go to SEND.
- SEND: keyData stays low (start bit) until the first negEdge. On negEdge k (k = 1..10), drive the k-th bit: d0..d7, then parity, then stop=1. A 1 bit releases keyData; a 0 bit drives it low. The value is held until the next negEdge. On negEdge 11, release keyData, sample ack = ~dSync, go to WAIT_IDLE.
- WAIT_IDLE: both lines released. When synced keyClock=1 and dSync=1, go to IDLE; txDone=1 for one cycle; txAck=ack.
- Timeout: the counter runs in SEND and WAIT_IDLE. When it reaches TIMEOUT_CYCLES-1, release both lines, pulse txError, go to IDLE; txDone stays 0.
- txStart while txBusy=1 is ignored; there is no queuing.
- txDone and txError are never asserted in the same cycle.
- Reset mid-frame releases the lines asynchronously; no done or error pulse follows.
- Latency: txBusy rises 1 cycle after txStart; keyClock goes low on the same edge.

Test Plan:
Bench parameters: INHIBIT_CYCLES=50, SETUP_CYCLES=10, TIMEOUT_CYCLES=20000. The device model clocks with a 400-cycle period and samples keyData on rising edges.
- txData=0xED -> keyClock low 50 cycles, then both lines low 10 cycles. Device samples start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1. Device acks -> txDone pulse, txAck=1, txBusy=0.
- txData=0x01 -> bits 1,0,0,0,0,0,0,0, parity 0, stop 1. txData=0x00 -> parity 1.
- Device keeps keyData high on the 11th clock -> txDone pulse, txAck=0, txError=0.
- Device never clocks -> txError pulse exactly 20000 cycles after keyClock release; both lines 'z'; txDone stays 0.
- reset=0 after the 5th negEdge -> keyClock and keyData 'z' with no clk edge, txBusy=0. A fresh 0xF4 transmit afterwards completes correctly.
- txStart pulsed again during SEND with 0x55 -> ignored; the frame still carries the original 0xED bits.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter on the shared open-drain keyClock/keyData lines.
// Frame: start, 8 data bits LSB first, odd parity, stop, then the device's ack bit.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int SETUP_CYCLES   = 100,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] txData,
  input  logic       txStart,
  output logic       txBusy,
  output logic       txDone,
  output logic       txAck,
  output logic       txError,
  inout  wire        keyClock,
  inout  wire        keyData
);

  localparam int PW = $clog2(INHIBIT_CYCLES + SETUP_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, WAIT_IDLE} state_t;

  state_t      state;
  logic        clkOe;
  logic        dataOe;
  logic [9:0]  shiftReg;
  logic [3:0]  bitIdx;
  logic [PW-1:0] phaseCnt;
  logic [TW-1:0] toCnt;
  logic        ackReg;

  logic clkS0, clkR1, clkR2;
  logic dataS0, dSync;
  logic negEdge;

  // Open-drain: only ever pull low, otherwise release.
  assign keyClock = clkOe  ? 1'b0 : 1'bz;
  assign keyData  = dataOe ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clkS0  <= 1'b0;
      clkR1  <= 1'b0;
      clkR2  <= 1'b0;
      dataS0 <= 1'b0;
      dSync  <= 1'b0;
    end else begin
      clkS0  <= keyClock;
      clkR1  <= clkS0;
      clkR2  <= clkR1;
      dataS0 <= keyData;
      dSync  <= dataS0;
    end
  end

  assign negEdge = ~clkR1 & clkR2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      clkOe    <= 1'b0;
      dataOe   <= 1'b0;
      shiftReg <= '0;
      bitIdx   <= '0;
      phaseCnt <= '0;
      toCnt    <= '0;
      ackReg   <= 1'b0;
      txBusy   <= 1'b0;
      txDone   <= 1'b0;
      txAck    <= 1'b0;
      txError  <= 1'b0;
    end else begin
      txDone  <= 1'b0;
      txError <= 1'b0;
      case (state)
        IDLE: begin
          clkOe  <= 1'b0;
          dataOe <= 1'b0;
          if (txStart) begin
            // Stop, odd parity, data; shifted out LSB first after the start bit.
            shiftReg <= {1'b1, ~^txData, txData};
            phaseCnt <= '0;
            toCnt    <= '0;
            bitIdx   <= '0;
            txAck    <= 1'b0;
            clkOe    <= 1'b1;
            txBusy   <= 1'b1;
            state    <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (phaseCnt == PW'(INHIBIT_CYCLES - 1)) begin
            phaseCnt <= '0;
            dataOe   <= 1'b1;
            state    <= REQ;
          end else begin
            phaseCnt <= phaseCnt + 1'b1;
          end
        end
        REQ: begin
          if (phaseCnt == PW'(SETUP_CYCLES - 1)) begin
            clkOe  <= 1'b0;
            toCnt  <= '0;
            bitIdx <= '0;
            state  <= SEND;
          end else begin
            phaseCnt <= phaseCnt + 1'b1;
          end
        end
        SEND: begin
          if (toCnt == TW'(TIMEOUT_CYCLES - 1)) begin
            clkOe   <= 1'b0;
            dataOe  <= 1'b0;
            txError <= 1'b1;
            txBusy  <= 1'b0;
            state   <= IDLE;
          end else begin
            toCnt <= toCnt + 1'b1;
            if (negEdge) begin
              if (bitIdx == 4'd10) begin
                dataOe <= 1'b0;
                ackReg <= ~dSync;
                state  <= WAIT_IDLE;
              end else begin
                dataOe   <= ~shiftReg[0];
                shiftReg <= shiftReg >> 1;
                bitIdx   <= bitIdx + 4'd1;
              end
            end
          end
        end
        WAIT_IDLE: begin
          if (toCnt == TW'(TIMEOUT_CYCLES - 1)) begin
            clkOe   <= 1'b0;
            dataOe  <= 1'b0;
            txError <= 1'b1;
            txBusy  <= 1'b0;
            state   <= IDLE;
          end else begin
            toCnt <= toCnt + 1'b1;
            // Device has released both lines: frame is over.
            if (clkR1 && dSync) begin
              txDone <= 1'b1;
              txAck  <= ackReg;
              txBusy <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        default: begin
          clkOe  <= 1'b0;
          dataOe <= 1'b0;
          txBusy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
